fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Parameters
REQ-001 SHALL provide parameter EXW, default 11: exponent field width in bits.
REQ-002 SHALL provide parameter FRW, default 52: fraction field width in bits.
REQ-003 SHALL use derived width W = 1+EXW+FRW and bias B = 2^(EXW-1)-1.

Interface
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  pipeline advance; low holds every stage, including outputs.
REQ-007 inValid  input  1  srca/srcb/rmode valid this cycle.
REQ-008 srca  input  W  operand A: sign, exponent, fraction.
REQ-009 srcb  input  W  operand B.
REQ-010 rmode  input  1  0 = round-nearest-even, 1 = round-toward-zero.
REQ-011 outValid  output  1  dst/flags valid.
REQ-012 dst  output  W  product.
REQ-013 flags  output  3  {invalid, overflow, underflow}.

Function
REQ-014 Operands SHALL be captured only when enable=1; inValid=0 SHALL carry a bubble (outValid=0 at the exit point).
REQ-015 Latency SHALL be exactly 3 enabled cycles; throughput 1 per enabled cycle; enable=0 cycles SHALL add no latency counts.
REQ-016 Stage 1: unpack, detect special cases, sign = sa^sb, exponent sum ea+eb-B in EXW+2-bit signed arithmetic.
REQ-017 Stage 2: full (FRW+1)x(FRW+1) product of hidden-1 mantissas; no pre-truncation of operands.
REQ-018 Stage 3: normalise (product MSB set -> shift right 1, exponent +1), round, pack, raise flags.
REQ-019 Rounding SHALL use guard bit plus sticky OR of all lower product bits; RNE rounds up when G=1 and (sticky=1 or LSB=1); RTZ truncates.
REQ-020 A rounding carry out of the mantissa SHALL renormalise (mantissa 1.0, exponent +1) before the overflow check.
REQ-021 Input exponent 0 (zero/denormal) SHALL be treated as signed zero (flush-to-zero).
REQ-022 Exponent >= 2^EXW-1 after rounding: overflow=1; RNE gives signed infinity, RTZ gives signed max-finite.
REQ-023 Exponent <= 0 after rounding: dst = signed zero, underflow=1.
REQ-024 Either input NaN, or infinity times zero: dst = canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0).
REQ-025 invalid=1 for infinity times zero or any signalling NaN input (exponent all ones, fraction MSB 0, fraction nonzero).
REQ-026 Infinity times finite nonzero SHALL give signed infinity with no flags; zero times finite SHALL give signed zero with no flags.
REQ-027 Special-case results SHALL bypass rounding and the overflow/underflow checks.
REQ-028 flags SHALL be 0 whenever outValid=0.

Reset
REQ-029 reset SHALL asynchronously clear all stage-valid bits, outValid, dst and flags to 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; nothing emerges after deassertion unless new inputs are issued.
REQ-031 The first capture after deassertion SHALL occur at the first rising edge with reset=0 and enable=1.

Verification (EXW=11, FRW=52)
REQ-032 Normal case: 0x3FF8000000000000 x 0x4000000000000000, enable=1 -> dst=0x4008000000000000, flags=0, outValid 3 cycles after issue.
REQ-033 Rounding, both modes:
- 0x3FF0000000000001 x 0x3FF8000000000000, rmode=0 -> dst=0x3FF8000000000002.
- Same operands, rmode=1 -> dst=0x3FF8000000000001.
REQ-034 Overflow:
- 0x7FE0000000000000 x 0x4000000000000000, rmode=0 -> dst=0x7FF0000000000000, overflow=1.
- Same operands, rmode=1 -> dst=0x7FEFFFFFFFFFFFFF, overflow=1.
REQ-035 Specials:
- 0x7FF0000000000000 x 0x0000000000000000 -> dst=0x7FF8000000000000, invalid=1.
- 0x0010000000000000 x 0x0010000000000000 -> dst=0, underflow=1.
REQ-036 Stall: issue 3 back-to-back ops, drop enable for 2 cycles after the second -> results appear in order, none lost or duplicated, and outputs are held while enable=0.
REQ-037 Reset mid-flight: issue 2 ops, pulse reset between clock edges -> outValid=0 and dst=0 immediately; no stale result appears afterwards.

Source files
------------

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Purpose  : Three-stage pipelined binary floating-point multiplier with
//            flush-to-zero inputs, RNE/RTZ rounding and IEEE-style flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
    parameter  int EXW = 11,
    parameter  int FRW = 52,
    localparam int W   = 1 + EXW + FRW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         inValid,
    input  logic [W-1:0] srca,
    input  logic [W-1:0] srcb,
    input  logic         rmode,
    output logic         outValid,
    output logic [W-1:0] dst,
    output logic [2:0]   flags
);

    // Product width and the signed exponent working width.
    localparam int PW = 2 * FRW + 2;
    localparam int XW = EXW + 2;

    localparam logic [XW-1:0] c_bias = {3'b000, {(EXW-1){1'b1}}};
    localparam logic [XW-1:0] c_emax = {2'b00, {EXW{1'b1}}};
    localparam logic [W-1:0]  c_qnan = {1'b0, {EXW{1'b1}}, 1'b1, {(FRW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1 inputs: field extraction and classification
    // ------------------------------------------------------------------
    logic [EXW-1:0] w_ea, w_eb;
    logic [FRW-1:0] w_fa, w_fb;
    logic           w_sign;
    logic           w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic           w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_inf_zero;
    logic           w_spec, w_spec_inv;
    logic [W-1:0]   w_spec_res;
    logic [XW-1:0]  w_exp_sum;

    assign w_ea       = srca[W-2:FRW];
    assign w_eb       = srcb[W-2:FRW];
    assign w_fa       = srca[FRW-1:0];
    assign w_fb       = srcb[FRW-1:0];
    assign w_sign     = srca[W-1] ^ srcb[W-1];
    assign w_a_nan    = (&w_ea) && (|w_fa);
    assign w_b_nan    = (&w_eb) && (|w_fb);
    assign w_a_snan   = w_a_nan && !w_fa[FRW-1];
    assign w_b_snan   = w_b_nan && !w_fb[FRW-1];
    assign w_a_inf    = (&w_ea) && !(|w_fa);
    assign w_b_inf    = (&w_eb) && !(|w_fb);
    // Zero exponent covers denormals too: they are flushed to signed zero.
    assign w_a_zero   = (w_ea == '0);
    assign w_b_zero   = (w_eb == '0);
    assign w_inf_zero = (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_exp_sum  = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;

    // Resolve special operand combinations into a final result up front.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_a_nan || w_b_nan || w_inf_zero) begin
            w_spec     = 1'b1;
            w_spec_res = c_qnan;
            w_spec_inv = w_inf_zero || w_a_snan || w_b_snan;
        end else if (w_a_inf || w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, {EXW{1'b1}}, {FRW{1'b0}}};
        end else if (w_a_zero || w_b_zero) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers, stages 1 and 2
    // ------------------------------------------------------------------
    logic           r1_valid, r1_sign, r1_spec, r1_inv, r1_rmode;
    logic [XW-1:0]  r1_exp;
    logic [FRW:0]   r1_ma, r1_mb;
    logic [W-1:0]   r1_spec_res;

    logic           r2_valid, r2_sign, r2_spec, r2_inv, r2_rmode;
    logic [XW-1:0]  r2_exp;
    logic [PW-1:0]  r2_prod;
    logic [W-1:0]   r2_spec_res;

    // Stage 1: capture unpacked operands, hidden-1 mantissas and specials.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_spec     <= 1'b0;
            r1_inv      <= 1'b0;
            r1_rmode    <= 1'b0;
            r1_exp      <= '0;
            r1_ma       <= '0;
            r1_mb       <= '0;
            r1_spec_res <= '0;
        end else if (enable) begin
            r1_valid    <= inValid;
            r1_sign     <= w_sign;
            r1_spec     <= w_spec;
            r1_inv      <= w_spec_inv;
            r1_rmode    <= rmode;
            r1_exp      <= w_exp_sum;
            r1_ma       <= {1'b1, w_fa};
            r1_mb       <= {1'b1, w_fb};
            r1_spec_res <= w_spec_res;
        end
    end

    // Stage 2: full-width mantissa product, everything else passes along.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_spec     <= 1'b0;
            r2_inv      <= 1'b0;
            r2_rmode    <= 1'b0;
            r2_exp      <= '0;
            r2_prod     <= '0;
            r2_spec_res <= '0;
        end else if (enable) begin
            r2_valid    <= r1_valid;
            r2_sign     <= r1_sign;
            r2_spec     <= r1_spec;
            r2_inv      <= r1_inv;
            r2_rmode    <= r1_rmode;
            r2_exp      <= r1_exp;
            r2_prod     <= {{(FRW+1){1'b0}}, r1_ma} * {{(FRW+1){1'b0}}, r1_mb};
            r2_spec_res <= r1_spec_res;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, range check, pack
    // ------------------------------------------------------------------
    logic [PW-2:0] w_norm;
    logic [FRW-1:0] w_frac, w_frac_r;
    logic          w_guard, w_sticky, w_rup;
    logic [FRW:0]  w_mant;
    logic [XW-1:0] w_exp_r;
    logic          w_ovf, w_unf;
    logic [W-1:0]  w_res;
    logic [2:0]    w_flg;

    // Product lies in [1,4); align so the leading one drops out at the top.
    assign w_norm   = r2_prod[PW-1] ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
    assign w_frac   = w_norm[PW-2 -: FRW];
    assign w_guard  = w_norm[FRW];
    assign w_sticky = |w_norm[FRW-1:0];
    assign w_rup    = !r2_rmode && w_guard && (w_sticky || w_frac[0]);
    // A carry out of the mantissa leaves the fraction all-zero (1.0) and
    // bumps the exponent, before the range checks look at it.
    assign w_mant   = {1'b0, w_frac} + {{FRW{1'b0}}, w_rup};
    assign w_frac_r = w_mant[FRW-1:0];
    assign w_exp_r  = r2_exp + {{(XW-1){1'b0}}, r2_prod[PW-1]}
                             + {{(XW-1){1'b0}}, w_mant[FRW]};
    assign w_ovf    = $signed(w_exp_r) >= $signed(c_emax);
    assign w_unf    = w_exp_r[XW-1] || (w_exp_r == '0);

    // Pick the special, saturated, flushed or normal result and its flags.
    always_comb begin
        w_res = {r2_sign, w_exp_r[EXW-1:0], w_frac_r};
        w_flg = 3'b000;
        if (r2_spec) begin
            w_res = r2_spec_res;
            w_flg = {r2_inv, 2'b00};
        end else if (w_ovf) begin
            w_flg = 3'b010;
            if (r2_rmode)
                w_res = {r2_sign, {(EXW-1){1'b1}}, 1'b0, {FRW{1'b1}}};
            else
                w_res = {r2_sign, {EXW{1'b1}}, {FRW{1'b0}}};
        end else if (w_unf) begin
            w_flg = 3'b001;
            w_res = {r2_sign, {(W-1){1'b0}}};
        end
    end

    // Output register; bubbles present zero data and zero flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            dst      <= '0;
            flags    <= 3'b000;
        end else if (enable) begin
            outValid <= r2_valid;
            dst      <= r2_valid ? w_res : '0;
            flags    <= r2_valid ? w_flg : 3'b000;
        end
    end

endmodule
`default_nettype wire
